ila_trigger_seq: RTL

- Multi-stage trigger sequencer directly upstream of the ILA core.
- Watches the raw trigger vector and steps through up to STAGES pattern-match stages, each with an occurrence count, followed by an optional post-match delay.
- Drives a single qualified trigger bit into one trigger input of the ILA core, so sampling can start on a complex event sequence instead of a single edge or level.

---
 rtl/ila_trig_seq_pkg.sv | 17 +
 rtl/ila_trig_seq_match.sv | 12 +
 rtl/ila_trigger_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ila_trig_seq_pkg.sv
// ila_trig_seq_pkg: shared state encoding and config-vector slicing for the ILA trigger sequencer.
// Contents: state_t (IDLE/MATCH/DELAY/FIRED, matching state_o), default widths, field_lo() slice helper.
package ila_trig_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_DELAY = 2'd2,
    ST_FIRED = 2'd3
  } state_t;
  localparam int DEF_TRIGGER_W = 4;
  localparam int DEF_STAGES    = 4;
  localparam int DEF_CNT_W     = 16;
  // Low bit of stage k's field inside a flattened per-stage config vector of field width w.
  function automatic int field_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/ila_trig_seq_match.sv
// ila_trig_seq_match: combinational care-masked pattern comparator for one sequencer stage.
// Ports: trig (registered trigger vector), mask (care bits), value (expected bits), hit (match).
module ila_trig_seq_match #(
  parameter int W = 4
) (
  input  logic [W-1:0] trig,
  input  logic [W-1:0] mask,
  input  logic [W-1:0] value,
  output logic         hit
);
  assign hit = ((trig ^ value) & mask) == '0;
endmodule

// File: rtl/ila_trigger_seq.sv
// ila_trigger_seq: multi-stage trigger sequencer producing one qualified trigger bit for an ILA core.
// Ports: clk_i/arst_n_i (async active-low reset)/cke_i (freezes all state), trigger_i (raw triggers),
//   arm_i/abort_i (control pulses), cfg_* (last stage, per-stage mask/value/count, post-match delay),
//   trig_o (qualified level), fire_o (rise pulse), state_o, stage_o.
// Optional: define ILA_TRIG_SEQ_TIMEOUT_EN to add cfg_timeout_i/timeout_o and the per-stage watchdog.
module ila_trigger_seq
  import ila_trig_seq_pkg::*;
#(
  parameter int TRIGGER_W = DEF_TRIGGER_W,
  parameter int STAGES    = DEF_STAGES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int STG_W     = $clog2(STAGES)
) (
  input  logic                        clk_i,
  input  logic                        arst_n_i,
  input  logic                        cke_i,
  input  logic [TRIGGER_W-1:0]        trigger_i,
  input  logic                        arm_i,
  input  logic                        abort_i,
  input  logic [STG_W-1:0]            cfg_last_stage_i,
  input  logic [STAGES*TRIGGER_W-1:0] cfg_mask_i,
  input  logic [STAGES*TRIGGER_W-1:0] cfg_value_i,
  input  logic [STAGES*CNT_W-1:0]     cfg_count_i,
  input  logic [CNT_W-1:0]            cfg_delay_i,
`ifdef ILA_TRIG_SEQ_TIMEOUT_EN
  input  logic [CNT_W-1:0]            cfg_timeout_i,
  output logic                        timeout_o,
`endif
  output logic                        trig_o,
  output logic                        fire_o,
  output logic [1:0]                  state_o,
  output logic [STG_W-1:0]            stage_o
);
  state_t             state, state_n;
  logic [STG_W-1:0]   stage, stage_n, last_l, last_n;
  logic [CNT_W-1:0]   mcnt, mcnt_n, dcnt, dcnt_n, delay_l, delay_n;
  logic [TRIGGER_W-1:0] trig_r;
  logic               fire_r, fire_n;
  logic [STAGES-1:0]  hits;
  logic [CNT_W-1:0]   cnts [STAGES];
  logic               hit, adv;
  logic [CNT_W-1:0]   need;
  logic [CNT_W:0]     mcnt_inc;
`ifdef ILA_TRIG_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0]   wd, wd_n;
  logic [CNT_W:0]     wd_inc;
  logic               tmo_r, tmo_n;
`endif
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ila_trig_seq_match #(.W(TRIGGER_W)) u_match (
      .trig  (trig_r),
      .mask  (cfg_mask_i[field_lo(k, TRIGGER_W) +: TRIGGER_W]),
      .value (cfg_value_i[field_lo(k, TRIGGER_W) +: TRIGGER_W]),
      .hit   (hits[k])
    );
    assign cnts[k] = cfg_count_i[field_lo(k, CNT_W) +: CNT_W];
  end
  assign hit  = hits[stage];
  // A programmed count of 0 behaves like 1 so a stage can never stall forever.
  assign need = cnts[stage] == '0 ? CNT_W'(1) : cnts[stage];
  // Compare one bit wider so counter+1 cannot wrap before the compare.
  assign mcnt_inc = {1'b0, mcnt} + (CNT_W+1)'(1);
  assign adv      = hit && mcnt_inc >= {1'b0, need};
`ifdef ILA_TRIG_SEQ_TIMEOUT_EN
  assign wd_inc = {1'b0, wd} + (CNT_W+1)'(1);
`endif
  always_comb begin
    state_n = state;
    stage_n = stage;
    mcnt_n  = mcnt;
    dcnt_n  = dcnt;
    last_n  = last_l;
    delay_n = delay_l;
`ifdef ILA_TRIG_SEQ_TIMEOUT_EN
    wd_n    = wd;
    tmo_n   = 1'b0;
`endif
    if (abort_i) begin
      state_n = ST_IDLE;
      stage_n = '0;
      mcnt_n  = '0;
      dcnt_n  = '0;
`ifdef ILA_TRIG_SEQ_TIMEOUT_EN
      wd_n    = '0;
`endif
    end else if (arm_i) begin
      state_n = ST_MATCH;
      stage_n = '0;
      mcnt_n  = '0;
      dcnt_n  = '0;
      last_n  = cfg_last_stage_i;
      delay_n = cfg_delay_i;
`ifdef ILA_TRIG_SEQ_TIMEOUT_EN
      wd_n    = '0;
`endif
    end else if (state == ST_MATCH) begin
      if (adv) begin
        mcnt_n = '0;
`ifdef ILA_TRIG_SEQ_TIMEOUT_EN
        wd_n   = '0;
`endif
        if (stage != last_l) stage_n = stage + STG_W'(1);
        else if (delay_l == '0) state_n = ST_FIRED;
        else begin
          state_n = ST_DELAY;
          dcnt_n  = delay_l - CNT_W'(1);
        end
      end else begin
        // Saturate rather than wrap on long runs of partial matches.
        if (hit) mcnt_n = &mcnt ? mcnt : mcnt_inc[CNT_W-1:0];
`ifdef ILA_TRIG_SEQ_TIMEOUT_EN
        if (stage != '0 && cfg_timeout_i != '0) begin
          if (wd_inc >= {1'b0, cfg_timeout_i}) begin
            stage_n = '0;
            mcnt_n  = '0;
            wd_n    = '0;
            tmo_n   = 1'b1;
          end else wd_n = wd_inc[CNT_W-1:0];
        end
`endif
      end
    end else if (state == ST_DELAY) begin
      state_n = dcnt == '0 ? ST_FIRED : ST_DELAY;
      dcnt_n  = dcnt == '0 ? dcnt : dcnt - CNT_W'(1);
    end
    fire_n = state_n == ST_FIRED && state != ST_FIRED;
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state   <= ST_IDLE;
      stage   <= '0;
      mcnt    <= '0;
      dcnt    <= '0;
      last_l  <= '0;
      delay_l <= '0;
      trig_r  <= '0;
      fire_r  <= 1'b0;
    end else if (cke_i) begin
      state   <= state_n;
      stage   <= stage_n;
      mcnt    <= mcnt_n;
      dcnt    <= dcnt_n;
      last_l  <= last_n;
      delay_l <= delay_n;
      trig_r  <= trigger_i;
      fire_r  <= fire_n;
    end
  end
`ifdef ILA_TRIG_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wd    <= '0;
      tmo_r <= 1'b0;
    end else if (cke_i) begin
      wd    <= wd_n;
      tmo_r <= tmo_n;
    end
  end
  assign timeout_o = tmo_r;
`endif
  assign trig_o  = state == ST_FIRED;
  assign fire_o  = fire_r;
  assign state_o = state;
  assign stage_o = stage;
endmodule
